// File: rtl/spi_flash_rd_seq_pkg.sv
// Shared encodings for the SPI flash read sequencer: engine access types,
// status bit position and the sequencer state type.
package spi_flash_rd_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSON,
        ST_TX,
        ST_POLL,
        ST_RDB,
        ST_NEXT,
        ST_CSOFF,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic        ctrl;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } access_t;

    localparam logic        CTRL_REG        = 1'b0;
    localparam logic        CTRL_DATA       = 1'b1;
    localparam logic [3:0]  WSTRB_WR        = 4'b0001;
    localparam logic [3:0]  WSTRB_RD        = 4'b0000;
    localparam int unsigned STATUS_BUSY_BIT = 31;

    localparam access_t ACC_CS_ON  = '{ctrl: CTRL_REG,  wstrb: WSTRB_WR, wdata: 32'd1};
    localparam access_t ACC_CS_OFF = '{ctrl: CTRL_REG,  wstrb: WSTRB_WR, wdata: 32'd0};
    localparam access_t ACC_POLL   = '{ctrl: CTRL_REG,  wstrb: WSTRB_RD, wdata: 32'd0};
    localparam access_t ACC_RDB    = '{ctrl: CTRL_DATA, wstrb: WSTRB_RD, wdata: 32'd0};

    function automatic access_t acc_tx(input logic [7:0] b);
        return '{ctrl: CTRL_DATA, wstrb: WSTRB_WR, wdata: {24'd0, b}};
    endfunction

endpackage

// File: rtl/spi_flash_rd_seq_access.sv
// Single engine access: latches the access on start, raises spi_valid once the
// inter-access gap has elapsed, holds it until spi_ready, then reports done.
module spi_bus_access
    import spi_flash_rd_seq_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  access_t     acc,
    output logic        done,
    output logic [31:0] rdata,
    output logic        spi_valid,
    output logic        spi_ctrl,
    output logic [31:0] spi_wdata,
    output logic [3:0]  spi_wstrb,
    input  logic        spi_ready,
    input  logic [31:0] spi_rdata
);

    localparam int unsigned         GAP_W    = $clog2(GAP_CYCLES) + 1;
    localparam logic [GAP_W-1:0]    GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    logic             pending;
    logic [GAP_W-1:0] gap_cnt;

    // gap_cnt loads GAP_CYCLES-1 on the handshake; the launch cycle adds the final low cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            done      <= 1'b0;
            rdata     <= '0;
            spi_valid <= 1'b0;
            spi_ctrl  <= 1'b0;
            spi_wdata <= '0;
            spi_wstrb <= '0;
            pending   <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            if (start) begin
                spi_ctrl  <= acc.ctrl;
                spi_wdata <= acc.wdata;
                spi_wstrb <= acc.wstrb;
                pending   <= 1'b1;
            end else if (pending && gap_cnt == '0) begin
                spi_valid <= 1'b1;
                pending   <= 1'b0;
            end
            if (spi_valid && spi_ready) begin
                spi_valid <= 1'b0;
                rdata     <= spi_rdata;
                done      <= 1'b1;
                gap_cnt   <= GAP_LOAD;
            end
        end
    end

endmodule

// File: rtl/spi_flash_rd_seq.sv
// Flash word-read sequencer: CS on, command, 24-bit address, dummy bytes,
// four data bytes, CS off; returns the word little-endian.
module spi_flash_rd_seq
    import spi_flash_rd_seq_pkg::*;
#(
    parameter logic [7:0]  CMD         = 8'h03,
    parameter int unsigned DUMMY_BYTES = 0,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [23:0] req_addr,
    output logic        req_ready,
    output logic [31:0] req_rdata,
    output logic        busy,
    output logic        spi_valid,
    output logic        spi_ctrl,
    output logic [31:0] spi_wdata,
    output logic [3:0]  spi_wstrb,
    input  logic        spi_ready,
    input  logic [31:0] spi_rdata
);

    localparam logic [3:0] LAST       = 4'(7 + DUMMY_BYTES);
    localparam logic [3:0] FIRST_DATA = 4'(4 + DUMMY_BYTES);

    state_t      state;
    logic [3:0]  idx;
    logic [23:0] addr;
    logic [31:0] data;
    logic        acc_start;
    access_t     acc;
    logic        acc_done;
    logic [31:0] acc_rdata;
    logic        unused_rdata;

    assign unused_rdata = ^acc_rdata[30:8];

    function automatic logic [7:0] byte_at(input logic [3:0] i, input logic [23:0] a);
        case (i)
            4'd0:    return CMD;
            4'd1:    return a[23:16];
            4'd2:    return a[15:8];
            4'd3:    return a[7:0];
            default: return 8'h00;
        endcase
    endfunction

    spi_bus_access #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_access (
        .clk       (clk),
        .resetn    (resetn),
        .start     (acc_start),
        .acc       (acc),
        .done      (acc_done),
        .rdata     (acc_rdata),
        .spi_valid (spi_valid),
        .spi_ctrl  (spi_ctrl),
        .spi_wdata (spi_wdata),
        .spi_wstrb (spi_wstrb),
        .spi_ready (spi_ready),
        .spi_rdata (spi_rdata)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            idx       <= '0;
            addr      <= '0;
            data      <= '0;
            busy      <= 1'b0;
            req_ready <= 1'b0;
            req_rdata <= '0;
            acc_start <= 1'b0;
            acc       <= '0;
        end else begin
            acc_start <= 1'b0;
            case (state)
                ST_IDLE: if (req_valid) begin
                    addr      <= req_addr;
                    busy      <= 1'b1;
                    idx       <= '0;
                    acc       <= ACC_CS_ON;
                    acc_start <= 1'b1;
                    state     <= ST_CSON;
                end
                ST_CSON: if (acc_done) begin
                    acc       <= acc_tx(byte_at(idx, addr));
                    acc_start <= 1'b1;
                    state     <= ST_TX;
                end
                ST_TX: if (acc_done) begin
                    acc       <= ACC_POLL;
                    acc_start <= 1'b1;
                    state     <= ST_POLL;
                end
                ST_POLL: if (acc_done) begin
                    if (acc_rdata[STATUS_BUSY_BIT]) begin
                        acc_start <= 1'b1;
                    end else if (idx >= FIRST_DATA) begin
                        acc       <= ACC_RDB;
                        acc_start <= 1'b1;
                        state     <= ST_RDB;
                    end else begin
                        state <= ST_NEXT;
                    end
                end
                ST_RDB: if (acc_done) begin
                    data  <= {acc_rdata[7:0], data[31:8]};
                    state <= ST_NEXT;
                end
                ST_NEXT: begin
                    acc_start <= 1'b1;
                    if (idx == LAST) begin
                        acc   <= ACC_CS_OFF;
                        state <= ST_CSOFF;
                    end else begin
                        idx   <= idx + 4'd1;
                        acc   <= acc_tx(byte_at(idx + 4'd1, addr));
                        state <= ST_TX;
                    end
                end
                ST_CSOFF: if (acc_done) begin
                    req_rdata <= data;
                    req_ready <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    req_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// Bench for spi_flash_rd_seq: unit 0 uses DUMMY_BYTES=0, unit 1 DUMMY_BYTES=1,
// each driven by an SPI engine + flash model with an access scoreboard.
module tb_spi_flash_rd_seq;

    localparam logic [36:0] A_CSON  = {1'b0, 4'b0001, 32'd1};
    localparam logic [36:0] A_CSOFF = {1'b0, 4'b0001, 32'd0};
    localparam logic [36:0] A_RDB   = {1'b1, 4'b0000, 32'd0};

    logic              clk;
    logic [1:0]        resetn;
    logic [1:0]        req_valid;
    logic [1:0][23:0]  req_addr;
    logic [1:0]        req_ready;
    logic [1:0][31:0]  req_rdata;
    logic [1:0]        busy;
    logic [1:0]        spi_valid;
    logic [1:0]        spi_ctrl;
    logic [1:0][31:0]  spi_wdata;
    logic [1:0][3:0]   spi_wstrb;
    logic [1:0]        spi_ready;
    logic [1:0][31:0]  spi_rdata;

    int total, bad;

    logic [36:0] exp0[$], exp1[$];
    logic [31:0] wexp0[$], wexp1[$];

    int          maxlat[2], bmin[2], bmax[2];
    int          lat[2], gap[2], bcnt[2], nbytes[2], rdbs[2];
    logic        inacc[2], had[2], expoll[2], seqopen[2], prevrdy[2];
    logic [36:0] cap[2];
    logic [23:0] fa[2];
    logic [7:0]  rx[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spi_flash_rd_seq #(.CMD(8'h03), .DUMMY_BYTES(0), .GAP_CYCLES(2)) dut0 (
        .clk(clk), .resetn(resetn[0]), .req_valid(req_valid[0]), .req_addr(req_addr[0]),
        .req_ready(req_ready[0]), .req_rdata(req_rdata[0]), .busy(busy[0]),
        .spi_valid(spi_valid[0]), .spi_ctrl(spi_ctrl[0]), .spi_wdata(spi_wdata[0]),
        .spi_wstrb(spi_wstrb[0]), .spi_ready(spi_ready[0]), .spi_rdata(spi_rdata[0])
    );

    spi_flash_rd_seq #(.CMD(8'h03), .DUMMY_BYTES(1), .GAP_CYCLES(2)) dut1 (
        .clk(clk), .resetn(resetn[1]), .req_valid(req_valid[1]), .req_addr(req_addr[1]),
        .req_ready(req_ready[1]), .req_rdata(req_rdata[1]), .busy(busy[1]),
        .spi_valid(spi_valid[1]), .spi_ctrl(spi_ctrl[1]), .spi_wdata(spi_wdata[1]),
        .spi_wstrb(spi_wstrb[1]), .spi_ready(spi_ready[1]), .spi_rdata(spi_rdata[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h001000: return 8'h11;
            24'h001001: return 8'h22;
            24'h001002: return 8'h33;
            24'h001003: return 8'h44;
            default:    return (a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    function automatic void push_acc(input int u, input logic [36:0] a);
        if (u == 0) exp0.push_back(a); else exp1.push_back(a);
    endfunction

    function automatic int acc_left(input int u);
        return (u == 0) ? exp0.size() : exp1.size();
    endfunction

    function automatic logic [36:0] tx(input logic [7:0] b);
        return {1'b1, 4'b0001, 24'd0, b};
    endfunction

    // Push the full expected access list and word, then raise the request.
    task automatic issue(input int u, input logic [23:0] a);
        logic [31:0] w;
        push_acc(u, A_CSON);
        push_acc(u, tx(8'h03));
        push_acc(u, tx(a[23:16]));
        push_acc(u, tx(a[15:8]));
        push_acc(u, tx(a[7:0]));
        for (int d = 0; d < u; d++) push_acc(u, tx(8'h00));
        for (int k = 0; k < 4; k++) begin
            push_acc(u, tx(8'h00));
            push_acc(u, A_RDB);
        end
        push_acc(u, A_CSOFF);
        w = {flash_byte(a + 24'd3), flash_byte(a + 24'd2), flash_byte(a + 24'd1), flash_byte(a)};
        if (u == 0) wexp0.push_back(w); else wexp1.push_back(w);
        req_addr[u]  = a;
        req_valid[u] = 1'b1;
    endtask

    task automatic wait_ready(input int u);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[u] && n < 6000);
        if (!req_ready[u]) chk("ready_timeout", req_ready[u], 1'b1);
    endtask

    task automatic check_reset(input int u);
        chk("rst_spi_valid", spi_valid[u], 1'b0);
        chk("rst_req_ready", req_ready[u], 1'b0);
        chk("rst_busy", busy[u], 1'b0);
        chk("rst_outputs", {req_rdata[u], spi_ctrl[u], spi_wdata[u], spi_wstrb[u]}, '0);
    endtask

    task automatic commit(input int u, input logic [36:0] cur);
        logic [36:0] e;
        e = '0;
        if (cur[36:32] == 5'b00000) begin
            chk("poll_expected", expoll[u], 1'b1);
            expoll[u]    = (bcnt[u] > 0);
            spi_rdata[u] = {expoll[u], 31'($urandom)};
        end else begin
            chk("poll_missing", expoll[u], 1'b0);
            if (u == 0) begin
                if (exp0.size() > 0) e = exp0.pop_front();
            end else begin
                if (exp1.size() > 0) e = exp1.pop_front();
            end
            if (e[35:32] == 4'b0000) chk("access_rd", cur[36:32], e[36:32]);
            else                     chk("access_wr", cur, e);
            spi_rdata[u] = $urandom;
            if (cur[36:32] == 5'b10001) begin
                if (nbytes[u] >= 1 && nbytes[u] <= 3) fa[u] = {fa[u][15:0], cur[7:0]};
                if (nbytes[u] >= 4 + u) rx[u] = flash_byte(fa[u] + 24'(nbytes[u] - 4 - u));
                else                    rx[u] = 8'hEE;
                nbytes[u]++;
                bcnt[u]   = $urandom_range(bmax[u], bmin[u]);
                expoll[u] = 1'b1;
            end else if (cur[36:32] == 5'b10000) begin
                spi_rdata[u] = {24'($urandom), rx[u]};
                rdbs[u]++;
            end else if (cur == A_CSON) begin
                chk("cs_on_while_open", seqopen[u], 1'b0);
                seqopen[u] = 1'b1;
                nbytes[u]  = 0;
                rdbs[u]    = 0;
            end
        end
    endtask

    task automatic engine_step(input int u);
        logic [36:0] cur;
        logic [31:0] w;
        cur = {spi_ctrl[u], spi_wstrb[u], spi_wdata[u]};
        if (!resetn[u]) begin
            spi_ready[u] = 1'b0;
            inacc[u] = 1'b0; had[u] = 1'b0; expoll[u] = 1'b0;
            seqopen[u] = 1'b0; prevrdy[u] = 1'b0;
            gap[u] = 0; bcnt[u] = 0; lat[u] = 0;
        end else begin
            if (prevrdy[u]) chk("busy_after_ready", busy[u], 1'b0);
            prevrdy[u] = req_ready[u];
            if (req_ready[u]) begin
                if (((u == 0) ? wexp0.size() : wexp1.size()) == 0) begin
                    chk("unexpected_ready", req_ready[u], 1'b0);
                end else begin
                    w = (u == 0) ? wexp0.pop_front() : wexp1.pop_front();
                    chk("rdata", req_rdata[u], w);
                    chk("busy_at_ready", busy[u], 1'b1);
                end
                seqopen[u] = 1'b0;
            end
            if (bcnt[u] > 0) bcnt[u]--;
            spi_ready[u] = 1'b0;
            if (spi_valid[u]) begin
                if (!inacc[u]) begin
                    inacc[u] = 1'b1;
                    cap[u]   = cur;
                    if (had[u]) chk("gap_ge2", (gap[u] >= 2), 1'b1);
                    lat[u] = $urandom_range(maxlat[u], 0);
                end else begin
                    chk("stable", cur, cap[u]);
                end
                if (lat[u] == 0) begin
                    spi_ready[u] = 1'b1;
                    commit(u, cur);
                    inacc[u] = 1'b0;
                    had[u]   = 1'b1;
                    gap[u]   = 0;
                end else begin
                    lat[u]--;
                end
            end else begin
                gap[u]++;
            end
        end
    endtask

    initial begin
        spi_ready = '0;
        spi_rdata = '0;
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) engine_step(u);
        end
    end

    initial begin
        int n;
        total = 0;
        bad   = 0;
        resetn    = '0;
        req_valid = '0;
        req_addr  = '0;
        maxlat[0] = 0; bmin[0] = 1; bmax[0] = 3;
        maxlat[1] = 2; bmin[1] = 2; bmax[1] = 10;

        // Reset held with a pending request, then the basic 0x001000 read.
        issue(0, 24'h001000);
        repeat (5) begin
            @(negedge clk);
            check_reset(0);
        end
        resetn = '1;
        wait_ready(0);
        req_valid[0] = 1'b0;
        chk("left_basic", acc_left(0), 0);

        // Random handshake latency and long engine busy.
        maxlat[0] = 5; bmin[0] = 8; bmax[0] = 40;
        repeat (3) @(negedge clk);
        issue(0, 24'h00ABC4);
        wait_ready(0);
        req_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        issue(0, 24'hFFFFFE);
        wait_ready(0);
        req_valid[0] = 1'b0;
        chk("left_random", acc_left(0), 0);

        // One dummy byte.
        issue(1, 24'hABCDEF);
        wait_ready(1);
        req_valid[1] = 1'b0;
        chk("left_dummy", acc_left(1), 0);

        // Back-to-back with req_valid held across both.
        repeat (3) @(negedge clk);
        issue(0, 24'h000200);
        wait_ready(0);
        issue(0, 24'h123456);
        wait_ready(0);
        req_valid[0] = 1'b0;
        chk("left_b2b", acc_left(0), 0);

        // Reset during the POLL after the third data byte.
        repeat (3) @(negedge clk);
        issue(0, 24'h0F0F00);
        n = 0;
        while (!(rdbs[0] == 2 && nbytes[0] == 7 && spi_valid[0] &&
                 spi_ctrl[0] == 1'b0 && spi_wstrb[0] == 4'b0000) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_third_poll", spi_valid[0], 1'b1);
        resetn[0]    = 1'b0;
        req_valid[0] = 1'b0;
        exp0.delete();
        wexp0.delete();
        repeat (3) begin
            @(negedge clk);
            check_reset(0);
        end
        resetn[0] = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_ready_after_reset", req_ready[0], 1'b0);
        issue(0, 24'h001000);
        wait_ready(0);
        req_valid[0] = 1'b0;
        chk("left_after_reset", acc_left(0), 0);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
